// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the handshaked pipeline-stage register.
//   pipe_state_e : occupancy of the stage (EMPTY, FULL, SKIDFULL).
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FULL     = 2'd1,
      SKIDFULL = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset, clears the count
//   inc_i  : add one this cycle (ignored once at all-ones)
//   clr_i  : synchronous clear, wins over inc_i
//   cnt_o  : current count
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count <= '0;
      end else if (clr_i) begin
         count <= '0;
      end else if (inc_i && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

   assign cnt_o = count;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline-stage register with optional skid entry,
// flush, bubble-safe control field and two saturating performance counters.
//   clk_i, rst_ni         : clock (rising edge), asynchronous active-low reset
//   valid_i/ready_o       : upstream handshake
//   data_i, ctrl_i        : upstream payload and control
//   valid_o/ready_i       : downstream handshake
//   data_o, ctrl_o        : head entry; ctrl_o forced to 0 when valid_o is low
//   flush_i               : drop held entries and the incoming one
//   cnt_clr_i             : synchronous clear of both counters
//   bubble_cnt_o          : cycles with valid_o low (saturating)
//   stall_cnt_o           : cycles with valid_o high and ready_i low (saturating)
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 96,
   parameter int unsigned CTRL_W = 8,
   parameter int unsigned SKID   = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic [CTRL_W-1:0] ctrl_o,
   input  logic              flush_i,
   input  logic              cnt_clr_i,
   output logic [CNT_W-1:0]  bubble_cnt_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   pipe_state_e       state;
   pipe_state_e       state_next;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic              in_fire;
   logic              out_fire;
   logic              load_main_in;
   logic              load_main_skid;

   assign in_fire  = valid_i & ready_o;
   assign out_fire = valid_o & ready_i;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; flush overrides every handshake
   always_comb begin
      state_next = state;
      if (flush_i) begin
         state_next = EMPTY;
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_fire) state_next = FULL;
            end
            FULL: begin
               if (in_fire && !out_fire) begin
                  // Unreachable without a skid: ready_o already requires ready_i when full
                  state_next = (SKID != 0) ? SKIDFULL : FULL;
               end else if (!in_fire && out_fire) begin
                  state_next = EMPTY;
               end
            end
            SKIDFULL: begin
               if (out_fire) state_next = FULL;
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   // Outputs; with a skid, ready_o depends on registered state only
   always_comb begin
      valid_o = (state != EMPTY);
      if (SKID != 0) begin
         ready_o = (state != SKIDFULL);
      end else begin
         ready_o = !valid_o || ready_i;
      end
      ctrl_o = valid_o ? main_ctrl : '0;
   end

   assign data_o = main_data;

   // Main register takes the input when it is (or is becoming) free, or the
   // skid entry when the head leaves from SKIDFULL so ordering is preserved.
   assign load_main_in   = !flush_i && in_fire && ((state == EMPTY) || out_fire);
   assign load_main_skid = !flush_i && (state == SKIDFULL) && out_fire;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         main_data <= '0;
         main_ctrl <= '0;
      end else if (load_main_skid) begin
         main_data <= skid_data;
         main_ctrl <= skid_ctrl;
      end else if (load_main_in) begin
         main_data <= data_i;
         main_ctrl <= ctrl_i;
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         logic load_skid;

         assign load_skid = !flush_i && (state == FULL) && in_fire && !out_fire;

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               skid_data <= '0;
               skid_ctrl <= '0;
            end else if (load_skid) begin
               skid_data <= data_i;
               skid_ctrl <= ctrl_i;
            end
         end
      end else begin : g_no_skid
         assign skid_data = '0;
         assign skid_ctrl = '0;
      end
   endgenerate

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_bubble_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (!valid_o),
      .clr_i  (cnt_clr_i),
      .cnt_o  (bubble_cnt_o)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (valid_o && !ready_i),
      .clr_i  (cnt_clr_i),
      .cnt_o  (stall_cnt_o)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed table on a skid instance (CNT_W=4), then
// randomized traffic on a skid and a no-skid instance against a queue model.
module tb_pipe_stage_reg;

   localparam int DW = 96;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          valid_in;
   logic          ready_in;
   logic          flush;
   logic          clr;
   logic [DW-1:0] data_in;
   logic [CW-1:0] ctrl_in;

   logic          s_ready, s_valid;
   logic [DW-1:0] s_data;
   logic [CW-1:0] s_ctrl;
   logic [3:0]    s_bub, s_stall;

   logic          n_ready, n_valid;
   logic [DW-1:0] n_data;
   logic [CW-1:0] n_ctrl;
   logic [15:0]   n_bub, n_stall;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_skid (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(s_ready),
      .data_i(data_in), .ctrl_i(ctrl_in), .valid_o(s_valid), .ready_i(ready_in),
      .data_o(s_data), .ctrl_o(s_ctrl), .flush_i(flush), .cnt_clr_i(clr),
      .bubble_cnt_o(s_bub), .stall_cnt_o(s_stall)
   );

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_noskid (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(n_ready),
      .data_i(data_in), .ctrl_i(ctrl_in), .valid_o(n_valid), .ready_i(ready_in),
      .data_o(n_data), .ctrl_o(n_ctrl), .flush_i(flush), .cnt_clr_i(clr),
      .bubble_cnt_o(n_bub), .stall_cnt_o(n_stall)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic          v, r, f, c_clr;
      logic [DW-1:0] d;
      logic [CW-1:0] c;
      logic          ev, er;
      logic [DW-1:0] ed;
      logic [CW-1:0] ec;
      logic [3:0]    es;
      logic          cb;
      logic [3:0]    eb;
   } vec_t;

   function automatic vec_t mkv(input logic v, input logic r, input logic f, input logic c_clr,
                                input int d, input int c, input logic ev, input logic er,
                                input int ed, input int ec, input int es, input logic cb,
                                input int eb);
      vec_t x;
      x.v = v; x.r = r; x.f = f; x.c_clr = c_clr;
      x.d = DW'(d); x.c = CW'(c);
      x.ev = ev; x.er = er; x.ed = DW'(ed); x.ec = CW'(ec);
      x.es = 4'(es); x.cb = cb; x.eb = 4'(eb);
      return x;
   endfunction

   // Apply at a negedge, check pre-edge outputs, advance to the next negedge
   task automatic apply_row(input vec_t x, input int idx);
      valid_in = x.v; ready_in = x.r; flush = x.f; clr = x.c_clr;
      data_in = x.d; ctrl_in = x.c;
      #1;
      chk($sformatf("row%0d valid", idx), 128'(s_valid), 128'(x.ev));
      chk($sformatf("row%0d ready", idx), 128'(s_ready), 128'(x.er));
      chk($sformatf("row%0d ctrl", idx), 128'(s_ctrl), 128'(x.ec));
      if (x.ev) chk($sformatf("row%0d data", idx), 128'(s_data), 128'(x.ed));
      chk($sformatf("row%0d stall", idx), 128'(s_stall), 128'(x.es));
      if (x.cb) chk($sformatf("row%0d bubble", idx), 128'(s_bub), 128'(x.eb));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         valid_in = 1'b0; ready_in = 1'b1; flush = 1'b0; clr = 1'b0;
         ctrl_in = 8'hFF;
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   typedef struct {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } ent_t;

   ent_t qs[$];
   ent_t qn[$];
   int   m_sb, m_ss, m_nb, m_ns;

   function automatic int sat_next(input int v, input logic inc, input logic c, input int max);
      if (c) return 0;
      if (inc && v < max) return v + 1;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1; flush = 1'b0; clr = 1'b0;
      data_in = '0; ctrl_in = '0;
      repeat (3) @(negedge clk);
      chk("rst valid", 128'(s_valid), 128'(0));
      chk("rst ctrl", 128'(s_ctrl), 128'(0));
      chk("rst data", 128'(s_data), 128'(0));
      chk("rst ready", 128'(s_ready), 128'(1));
      chk("rst bubble", 128'(s_bub), 128'(0));
      chk("rst noskid ready", 128'(n_ready), 128'(1));
      rst_n = 1'b1;

      // Streaming, skid absorb, flush in SKIDFULL, bubble ctrl and clear
      tbl.push_back(mkv(1,1,0,0, 1,'h11, 0,1,0,0,    0,0,0));
      tbl.push_back(mkv(1,1,0,0, 2,'h12, 1,1,1,'h11, 0,0,0));
      tbl.push_back(mkv(1,1,0,0, 3,'h13, 1,1,2,'h12, 0,0,0));
      tbl.push_back(mkv(1,1,0,0, 4,'h14, 1,1,3,'h13, 0,0,0));
      tbl.push_back(mkv(1,1,0,0, 5,'h15, 1,1,4,'h14, 0,0,0));
      tbl.push_back(mkv(0,1,0,0, 0,'hFF, 1,1,5,'h15, 0,0,0));
      tbl.push_back(mkv(0,1,0,0, 0,'hFF, 0,1,0,0,    0,0,0));
      tbl.push_back(mkv(1,1,0,0, 'hA,'hA1, 0,1,0,0,  0,0,0));
      tbl.push_back(mkv(1,0,0,0, 'hB,'hB1, 1,1,'hA,'hA1, 0,0,0));
      tbl.push_back(mkv(0,1,0,0, 0,'hFF, 1,0,'hA,'hA1, 1,0,0));
      tbl.push_back(mkv(0,1,0,0, 0,'hFF, 1,1,'hB,'hB1, 1,0,0));
      tbl.push_back(mkv(0,1,0,0, 0,'hFF, 0,1,0,0,    1,0,0));
      tbl.push_back(mkv(1,0,0,0, 'hA,'hA1, 0,1,0,0,  1,0,0));
      tbl.push_back(mkv(1,0,0,0, 'hB,'hB1, 1,1,'hA,'hA1, 1,0,0));
      tbl.push_back(mkv(1,0,1,0, 'hC,'hC1, 1,0,'hA,'hA1, 2,0,0));
      tbl.push_back(mkv(0,1,0,0, 0,'hFF, 0,1,0,0,    3,0,0));
      tbl.push_back(mkv(0,1,0,0, 0,'hFF, 0,1,0,0,    3,0,0));
      tbl.push_back(mkv(0,1,0,1, 0,'hFF, 0,1,0,0,    3,0,0));
      tbl.push_back(mkv(0,1,0,0, 0,'hFF, 0,1,0,0,    0,1,0));
      tbl.push_back(mkv(0,1,0,0, 0,'hFF, 0,1,0,0,    0,1,1));
      tbl.push_back(mkv(0,1,0,0, 0,'hFF, 0,1,0,0,    0,1,2));
      tbl.push_back(mkv(0,1,0,0, 0,'hFF, 0,1,0,0,    0,1,3));
      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i], i);

      // Saturation at 15 and clear
      idle(20);
      chk("sat bubble", 128'(s_bub), 128'(15));
      idle(1);
      chk("sat bubble held", 128'(s_bub), 128'(15));
      clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      chk("clr bubble 0", 128'(s_bub), 128'(0));
      @(posedge clk);
      @(negedge clk);
      chk("clr bubble 1", 128'(s_bub), 128'(1));

      // Async reset while SKIDFULL, between clock edges
      valid_in = 1'b1; ready_in = 1'b0; data_in = 'hA; ctrl_in = 8'hA1;
      @(posedge clk); @(negedge clk);
      data_in = 'hB; ctrl_in = 8'hB1;
      @(posedge clk); @(negedge clk);
      valid_in = 1'b0;
      #1;
      chk("skidfull ready", 128'(s_ready), 128'(0));
      #1 rst_n = 1'b0;
      #1;
      chk("async valid", 128'(s_valid), 128'(0));
      chk("async ctrl", 128'(s_ctrl), 128'(0));
      chk("async data", 128'(s_data), 128'(0));
      chk("async ready", 128'(s_ready), 128'(1));
      chk("async stall", 128'(s_stall), 128'(0));
      @(negedge clk);
      ready_in = 1'b1;
      rst_n = 1'b1;
      qs.delete(); qn.delete();
      m_sb = 0; m_ss = 0; m_nb = 0; m_ns = 0;

      // Randomized traffic on both instances against the queue model
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic exp_sr, exp_nr, s_in, n_in, s_out, n_out;
         valid_in = ($urandom_range(0, 9) < 7);
         ready_in = ($urandom_range(0, 9) < 6);
         flush    = ($urandom_range(0, 99) < 3);
         clr      = ($urandom_range(0, 99) < 2);
         data_in  = {$urandom(), $urandom(), $urandom()};
         ctrl_in  = 8'($urandom());
         #1;
         exp_sr = (qs.size() < 2);
         exp_nr = (qn.size() == 0) || ready_in;
         chk("rnd s ready", 128'(s_ready), 128'(exp_sr));
         chk("rnd s valid", 128'(s_valid), 128'(qs.size() != 0));
         chk("rnd s ctrl", 128'(s_ctrl), 128'((qs.size() != 0) ? qs[0].c : 8'h00));
         if (qs.size() != 0) chk("rnd s data", 128'(s_data), 128'(qs[0].d));
         chk("rnd s bubble", 128'(s_bub), 128'(m_sb));
         chk("rnd s stall", 128'(s_stall), 128'(m_ss));
         chk("rnd n ready", 128'(n_ready), 128'(exp_nr));
         chk("rnd n valid", 128'(n_valid), 128'(qn.size() != 0));
         chk("rnd n ctrl", 128'(n_ctrl), 128'((qn.size() != 0) ? qn[0].c : 8'h00));
         if (qn.size() != 0) chk("rnd n data", 128'(n_data), 128'(qn[0].d));
         chk("rnd n bubble", 128'(n_bub), 128'(m_nb));
         chk("rnd n stall", 128'(n_stall), 128'(m_ns));

         s_in  = valid_in && exp_sr;
         n_in  = valid_in && exp_nr;
         s_out = (qs.size() != 0) && ready_in;
         n_out = (qn.size() != 0) && ready_in;
         m_sb = sat_next(m_sb, qs.size() == 0, clr, 15);
         m_ss = sat_next(m_ss, (qs.size() != 0) && !ready_in, clr, 15);
         m_nb = sat_next(m_nb, qn.size() == 0, clr, 65535);
         m_ns = sat_next(m_ns, (qn.size() != 0) && !ready_in, clr, 65535);
         if (flush) begin
            qs.delete();
            qn.delete();
         end else begin
            if (s_out) void'(qs.pop_front());
            if (s_in) qs.push_back('{d: data_in, c: ctrl_in});
            if (n_out) void'(qn.pop_front());
            if (n_in) qn.push_back('{d: data_in, c: ctrl_in});
         end
         @(posedge clk);
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
